// File: rtl/irq_source_arbiter.sv
// irq_source_arbiter
// Collects interrupt lines from peripherals, latches them as pending, and
// forwards one at a time (lowest index first) to the core interrupt
// controller on a single request line. The request is held until the
// controller signals return-from-interrupt. The served source then gets a
// one-cycle acknowledge, and its pending bit is cleared.
module irq_source_arbiter #(
   parameter int                 N_SRC    = 16,
   parameter logic [N_SRC-1:0]   EDGE_SRC = {N_SRC{1'b1}}
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [N_SRC-1:0]           src_irq_i,
   input  logic [N_SRC-1:0]           src_en_i,
   input  logic                       irq_ret_i,
   output logic                       irq_req_o,
   output logic [$clog2(N_SRC)-1:0]   irq_id_o,
   output logic [N_SRC-1:0]           src_ack_o,
   output logic [N_SRC-1:0]           pending_o
);

   localparam int ID_W = $clog2(N_SRC);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [N_SRC-1:0]    pending_q, pending_d;
   logic [N_SRC-1:0]    src_prev_q;
   logic [ID_W-1:0]     irq_id_q, irq_id_d;

   logic [N_SRC-1:0]    set_vec;
   logic [N_SRC-1:0]    clr_vec;
   logic [N_SRC-1:0]    served_oh;
   logic [N_SRC-1:0]    eligible;
   logic                any_eligible;
   logic [ID_W-1:0]     win_id;

   // Per-source detection: rising edge against the history register, or the
   // raw line for level sources. Also decode the served id to one-hot.
   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi = gi + 1) begin : g_src
         if (EDGE_SRC[gi]) begin : g_edge
            assign set_vec[gi] = src_irq_i[gi] & ~src_prev_q[gi];
         end else begin : g_level
            assign set_vec[gi] = src_irq_i[gi];
         end
         assign served_oh[gi] = (irq_id_q == ID_W'(gi));
      end
   endgenerate

   // Pending stays latched whether or not the source is enabled; the enable
   // only gates eligibility for arbitration.
   assign eligible     = pending_q & src_en_i;
   assign any_eligible = |eligible;

   // Fixed priority: lowest eligible index wins. The loop runs downward so
   // the last assignment to take effect is the lowest index.
   always_comb begin
      win_id = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_id = ID_W'(i);
         end
      end
   end

   // Clear mask applies only in the acknowledge cycle.
   assign clr_vec = (state_q == ST_ACK) ? served_oh : '0;

   // A new set in the same cycle as the clear takes priority, so a source
   // that re-fires during its own acknowledge is served again.
   assign pending_d = (pending_q & ~clr_vec) | set_vec;

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: edge history, pending latch and served id.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         src_prev_q <= '0;
         pending_q  <= '0;
         irq_id_q   <= '0;
      end else begin
         src_prev_q <= src_irq_i;
         pending_q  <= pending_d;
         irq_id_q   <= irq_id_d;
      end
   end

   // Next-state logic. The served id is captured only when leaving IDLE;
   // it stays frozen through REQ and ACK.
   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_eligible) begin
               irq_id_d = win_id;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (irq_ret_i) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs derived from the registered state only.
   always_comb begin
      irq_req_o = 1'b0;
      src_ack_o = '0;
      unique case (state_q)
         ST_REQ:  irq_req_o = 1'b1;
         ST_ACK:  src_ack_o = served_oh;
         default: begin
            irq_req_o = 1'b0;
            src_ack_o = '0;
         end
      endcase
   end

   assign irq_id_o  = irq_id_q;
   assign pending_o = pending_q;

endmodule
